// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache: FSM state encoding, default
// geometry and a width helper.
package cache_pkg;

  localparam int unsigned DEF_WORD_W          = 32;
  localparam int unsigned DEF_ADDR_W          = 12;
  localparam int unsigned DEF_WORDS_PER_BLOCK = 4;
  localparam int unsigned DEF_SETS            = 4;
  localparam int unsigned DEF_WAYS            = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } cacheState_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clogMin1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping: one age per way per set; the accessed way becomes
// age 0 and every way younger than it ages by one. Victim is the lowest
// invalid way, otherwise the oldest way.
module cache_lru
  import cache_pkg::*;
#(
  parameter  int unsigned SETS  = DEF_SETS,
  parameter  int unsigned WAYS  = DEF_WAYS,
  localparam int unsigned IDX_W = clogMin1(SETS),
  localparam int unsigned WAY_W = clogMin1(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] setIdx,
  input  logic             touch,
  input  logic [WAY_W-1:0] touchWay,
  input  logic [WAYS-1:0]  setValid,
  output logic [WAY_W-1:0] victimWay
);

  logic [WAY_W-1:0] ages [SETS][WAYS];
  logic             foundInv;

  // Age update on access; reset gives way w the age w.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          ages[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touchWay)
          ages[setIdx][w] <= '0;
        else if (ages[setIdx][w] < ages[setIdx][touchWay])
          ages[setIdx][w] <= ages[setIdx][w] + WAY_W'(1);
      end
    end
  end

  // Victim select: oldest way, overridden by the lowest-index invalid way.
  always_comb begin
    victimWay = '0;
    foundInv  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++)
      if (ages[setIdx][w] == WAY_W'(WAYS - 1))
        victimWay = WAY_W'(w);
    for (int unsigned w = 0; w < WAYS; w++)
      if (!setValid[w] && !foundInv) begin
        victimWay = WAY_W'(w);
        foundInv  = 1'b1;
      end
  end

endmodule

// File: rtl/cache_nway.sv
// Write-back, write-allocate N-way set-associative cache with a block
// memory port. Optional statistics counters under `CACHE_STATS_EN.
// Geometry assumes SETS >= 2 and WORDS_PER_BLOCK >= 2.
module cache_nway
  import cache_pkg::*;
#(
  parameter int unsigned WORD_W          = DEF_WORD_W,
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned SETS            = DEF_SETS,
  parameter int unsigned WAYS            = DEF_WAYS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              isRead,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [WORD_W-1:0]                 writeData,
  output logic                              resp_valid,
  output logic [WORD_W-1:0]                 readData,
  output logic                              isHit,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                              mem_ack,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W = clogMin1(WAYS);
  localparam int unsigned BLK_W = WORD_W * WORDS_PER_BLOCK;

  cacheState_t state, nextState;

  logic              reqRead;
  logic [ADDR_W-1:0] reqAddr;
  logic [WORD_W-1:0] reqWData;
  logic              refilled;
  logic [OFF_W-1:0]  reqOff;
  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;

  logic [BLK_W-1:0]  dataArr  [SETS][WAYS];
  logic [TAG_W-1:0]  tagArr   [SETS][WAYS];
  logic [WAYS-1:0]   validArr [SETS];
  logic [WAYS-1:0]   dirtyArr [SETS];

  logic              hit;
  logic              lookupHit;
  logic [WAY_W-1:0]  hitWay;
  logic [WAY_W-1:0]  victimWay;
  logic [WAY_W-1:0]  victimLat;

  assign reqOff    = reqAddr[OFF_W-1:0];
  assign reqIdx    = reqAddr[OFF_W +: IDX_W];
  assign reqTag    = reqAddr[ADDR_W-1 -: TAG_W];
  assign lookupHit = (state == LOOKUP) && hit;

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) uLru (
    .clk       (clk),
    .rst       (rst),
    .setIdx    (reqIdx),
    .touch     (lookupHit),
    .touchWay  (hitWay),
    .setValid  (validArr[reqIdx]),
    .victimWay (victimWay)
  );

  // Tag compare across the ways of the latched request's set.
  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      if (validArr[reqIdx][w] && (tagArr[reqIdx][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and memory-port outputs.
  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nextState = LOOKUP;
      end
      LOOKUP: begin
        if (hit)
          nextState = IDLE;
        else if (validArr[reqIdx][victimWay] && dirtyArr[reqIdx][victimWay])
          nextState = WRITEBACK;
        else
          nextState = ALLOCATE;
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tagArr[reqIdx][victimLat], reqIdx, {OFF_W{1'b0}}};
        mem_wdata = dataArr[reqIdx][victimLat];
        if (mem_ack) nextState = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {reqTag, reqIdx, {OFF_W{1'b0}}};
        if (mem_ack) nextState = LOOKUP;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request latch, victim latch and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      readData   <= '0;
      isHit      <= 1'b0;
      refilled   <= 1'b0;
      reqRead    <= 1'b0;
      reqAddr    <= '0;
      reqWData   <= '0;
      victimLat  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        reqRead  <= isRead;
        reqAddr  <= address;
        reqWData <= writeData;
        refilled <= 1'b0;
      end
      if (state == LOOKUP) begin
        if (hit) begin
          resp_valid <= 1'b1;
          isHit      <= !refilled;
          readData   <= reqRead ? dataArr[reqIdx][hitWay][reqOff*WORD_W +: WORD_W]
                                : reqWData;
        end else begin
          refilled  <= 1'b1;
          victimLat <= victimWay;
        end
      end
    end
  end

  // Line status bits: dirty on write hit, clean+valid on refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        validArr[s] <= '0;
        dirtyArr[s] <= '0;
      end
    end else begin
      if (lookupHit && !reqRead)
        dirtyArr[reqIdx][hitWay] <= 1'b1;
      if (state == ALLOCATE && mem_ack) begin
        validArr[reqIdx][victimLat] <= 1'b1;
        dirtyArr[reqIdx][victimLat] <= 1'b0;
      end
    end
  end

  // Data and tag storage; contents are don't-care while the line is invalid.
  always_ff @(posedge clk) begin
    if (lookupHit && !reqRead)
      dataArr[reqIdx][hitWay][reqOff*WORD_W +: WORD_W] <= reqWData;
    if (state == ALLOCATE && mem_ack) begin
      dataArr[reqIdx][victimLat] <= mem_rdata;
      tagArr[reqIdx][victimLat]  <= reqTag;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, stepped with each response.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookupHit) begin
      if (!refilled) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: directed scenarios plus randomized
// traffic against a recency-list cache model and a behavioural memory.
module tb_cache_nway;

  localparam int unsigned WW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned WPB = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned MEMW = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              isRead;
  logic [AW-1:0]     address;
  logic [WW-1:0]     writeData;
  logic              resp_valid;
  logic [WW-1:0]     readData;
  logic              isHit;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WW*WPB-1:0] mem_wdata;
  logic [WW*WPB-1:0] mem_rdata;
  logic              mem_ack;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  always #5 clk = ~clk;

  cache_nway #(
    .WORD_W          (WW),
    .ADDR_W          (AW),
    .WORDS_PER_BLOCK (WPB),
    .SETS            (NS),
    .WAYS            (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .isRead     (isRead),
    .address    (address),
    .writeData  (writeData),
    .resp_valid (resp_valid),
    .readData   (readData),
    .isHit      (isHit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memInit(input int unsigned i);
    if (i == 0) return 32'h3cc3;
    return (i * 32'h9e3779b1) ^ 32'h0000a5a5;
  endfunction

  // ---------------- memory: acks on the 3rd cycle of mem_req ----------------
  logic [31:0]   memArr [MEMW];
  int            wbCount = 0;
  int            allocCount = 0;
  logic [AW-1:0] lastWbAddr = '0;
  logic [AW-1:0] lastAllocAddr = '0;

  initial begin
    int memCnt;
    int base;
    for (int i = 0; i < int'(MEMW); i++) memArr[i] = memInit(i);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    memCnt    = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req) memCnt = 0;
      else begin
        memCnt++;
        if (memCnt == 3) begin
          memCnt  = 0;
          mem_ack = 1'b1;
          base    = int'(mem_addr);
          if (mem_we) begin
            for (int o = 0; o < int'(WPB); o++) memArr[base + o] = mem_wdata[o*32 +: 32];
            wbCount++;
            lastWbAddr = mem_addr;
          end else begin
            for (int o = 0; o < int'(WPB); o++) mem_rdata[o*32 +: 32] = memArr[base + o];
            allocCount++;
            lastAllocAddr = mem_addr;
          end
        end
      end
    end
  end

  // ---------------- reference model: per-set recency lists ----------------
  typedef struct {
    int unsigned  tag;
    bit           dirty;
    logic [127:0] data;
  } line_t;

  line_t       setQ [NS][$];
  logic [31:0] modelMem [MEMW];
  int          expHits = 0;
  int          expMisses = 0;

  task automatic modelReset();
    for (int s = 0; s < int'(NS); s++) setQ[s].delete();
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic modelAccess(input bit rd, input int unsigned addr, input logic [31:0] wd,
                             output bit eHit, output logic [31:0] eData,
                             output bit eWb, output int unsigned eWbAddr);
    int unsigned idx, tag, off, blk;
    int          pos;
    line_t       ln, v;
    idx = (addr / WPB) % NS;
    tag = addr / (WPB * NS);
    off = addr % WPB;
    blk = addr - off;
    eHit = 0; eWb = 0; eWbAddr = 0; pos = -1;
    for (int i = 0; i < setQ[idx].size(); i++)
      if (setQ[idx][i].tag == tag) pos = i;
    if (pos >= 0) begin
      ln = setQ[idx][pos];
      setQ[idx].delete(pos);
      eHit = 1;
    end else begin
      if (setQ[idx].size() == int'(NW)) begin
        v = setQ[idx].pop_back();
        if (v.dirty) begin
          eWb = 1;
          eWbAddr = v.tag * WPB * NS + idx * WPB;
          for (int o = 0; o < int'(WPB); o++) modelMem[eWbAddr + o] = v.data[o*32 +: 32];
        end
      end
      ln.tag = tag;
      ln.dirty = 0;
      for (int o = 0; o < int'(WPB); o++) ln.data[o*32 +: 32] = modelMem[blk + o];
    end
    if (rd) eData = ln.data[off*32 +: 32];
    else begin
      ln.data[off*32 +: 32] = wd;
      ln.dirty = 1;
      eData = wd;
    end
    setQ[idx].push_front(ln);
  endtask

  task automatic checkStats();
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 64'(expHits));
    chk("miss_count", miss_count, 64'(expMisses));
`else
    chk("hit_count tied off", hit_count, 0);
    chk("miss_count tied off", miss_count, 0);
`endif
  endtask

  // ---------------- one request, fully checked against the model ----------------
  task automatic runReq(input bit rd, input int unsigned addr, input logic [31:0] wd,
                        output logic [31:0] gotData, output bit gotHit);
    bit          eHit, eWb, seen;
    logic [31:0] eData;
    int unsigned eWbAddr;
    int          wb0, al0, cyc, mrc;
    modelAccess(rd, addr, wd, eHit, eData, eWb, eWbAddr);
    wb0 = wbCount; al0 = allocCount;
    gotData = '0; gotHit = 0;
    chk("req_ready when idle", req_ready, 1);
    req_valid = 1'b1; isRead = rd; address = AW'(addr); writeData = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    isRead    = 1'($urandom_range(0, 1));
    address   = AW'($urandom);
    writeData = $urandom;
    cyc = 0; mrc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_valid) seen = 1;
      else begin
        chk("req_ready while busy", req_ready, 0);
        if (mem_req) mrc++;
      end
    end
    chk("response timeout", seen, 1);
    if (seen) begin
      if (eHit) expHits++; else expMisses++;
      chk("isHit", isHit, eHit);
      if (rd) chk("readData", readData, eData);
      if (eHit) begin
        chk("hit latency", cyc, 1);
        chk("mem_req cycles on hit", mrc, 0);
      end
      chk("writeback count", wbCount - wb0, eWb);
      if (eWb) chk("writeback addr", lastWbAddr, eWbAddr);
      chk("allocate count", allocCount - al0, eHit ? 0 : 1);
      if (!eHit) chk("allocate addr", lastAllocAddr, addr & ~(WPB - 1));
      gotData = readData;
      gotHit  = isHit;
      @(posedge clk); #1;
      chk("resp_valid single pulse", resp_valid, 0);
      checkStats();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          h, found;
    int          mism;
    for (int i = 0; i < int'(MEMW); i++) modelMem[i] = memInit(i);
    modelReset();
    rst = 1'b1; req_valid = 1'b0; isRead = 1'b0; address = '0; writeData = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset readData", readData, 0);
    chk("reset isHit", isHit, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset hit_count", hit_count, 0);
    chk("reset miss_count", miss_count, 0);
    rst = 1'b0;

    // cold read, then write/read hits, then fills and a dirty eviction in set 0
    runReq(1, 'h000, '0, d, h);
    chk("cold read data", d, 32'h3cc3);
    chk("cold read isHit", h, 0);
    chk("cold read alloc addr", lastAllocAddr, 0);
    runReq(0, 'h000, 32'hff, d, h);
    chk("write hit isHit", h, 1);
    runReq(1, 'h000, '0, d, h);
    chk("read after write data", d, 32'hff);
    chk("read after write isHit", h, 1);
    chk("memory word 0 untouched", memArr[0], 32'h3cc3);
    runReq(1, 'h010, '0, d, h);
    chk("second tag isHit", h, 0);
    chk("no writeback into invalid way", wbCount, 0);
    runReq(1, 'h020, '0, d, h);
    chk("eviction isHit", h, 0);
    chk("eviction writeback addr", lastWbAddr, 0);
    chk("memory word 0 written back", memArr[0], 32'hff);
`ifdef CACHE_STATS_EN
    chk("directed hit_count", hit_count, 2);
    chk("directed miss_count", miss_count, 3);
`endif

    // make tag 1 dirty and LRU, then reset mid-writeback
    runReq(0, 'h010, 32'h1234, d, h);
    runReq(1, 'h020, '0, d, h);
    req_valid = 1'b1; isRead = 1'b1; address = 12'h040; writeData = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we) found = 1;
    end
    chk("writeback started", found, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort mem_req", mem_req, 0);
    chk("abort resp_valid", resp_valid, 0);
    chk("abort req_ready", req_ready, 1);
    rst = 1'b0;
    modelReset();
    checkStats();
    chk("aborted writeback left memory", memArr['h10], memInit('h10));
    runReq(1, 'h000, '0, d, h);
    chk("read after abort isHit", h, 0);
    chk("read after abort data", d, 32'hff);

    // randomized traffic, mostly within 4 tags per set to force conflicts
    for (int n = 0; n < 400; n++) begin
      int unsigned a;
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MEMW - 1) : $urandom_range(0, 63);
      runReq(1'($urandom_range(0, 1)), a, $urandom, d, h);
    end

    mism = 0;
    for (int i = 0; i < int'(MEMW); i++)
      if (memArr[i] !== modelMem[i]) mism++;
    chk("memory image mismatching words", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
